ifetch_unit: RTL



---
 rtl/ifetch_if.sv | 50 +++++
 rtl/ifetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_if.sv
//------------------------------------------------------------------------------
// Module      : ifetch_if
// Description : PC, instruction-memory and decode-side signals of the fetch
//               stage. The bus-error signals exist only with IFETCH_BUS_ERR_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ifetch_if;
    logic [31:0] pc_current;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_ready;
`ifdef IFETCH_BUS_ERR_EN
    logic        imem_err;
    logic        instr_bus_err;
`endif

    // Fetch unit side
    modport slave (
        input  pc_current, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
`ifdef IFETCH_BUS_ERR_EN
        input  imem_err,
        output instr_bus_err,
`endif
        output pc_ready, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_fault
    );

    // PC register / memory / decode side
    modport master (
        output pc_current, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
`ifdef IFETCH_BUS_ERR_EN
        output imem_err,
        input  instr_bus_err,
`endif
        input  pc_ready, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_fault
    );
endinterface

`default_nettype wire

// File: rtl/ifetch_unit.sv
//------------------------------------------------------------------------------
// Module      : ifetch_unit
// Description : RV32I instruction fetch stage: one outstanding req/gnt/rvalid
//               fetch, small instruction FIFO, flush and misalignment faults.
//               Optional macro IFETCH_BUS_ERR_EN adds imem_err/instr_bus_err.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_unit #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic     clk,
    input  logic     reset,
    ifetch_if.slave  fetch_if
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t             state_q;
    logic               imem_req_q;
    logic [31:0]        imem_addr_q;
    logic               flush_seen_q;

    logic [31:0]        fifo_instr_q [DEPTH];
    logic [31:0]        fifo_pc_q    [DEPTH];
    logic               fifo_fault_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               w_pc_ready;
    logic               w_accept;
    logic               w_aligned;
    logic               w_push_mis;
    logic               w_push_mem;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_push_instr;
    logic [31:0]        w_push_pc;
    logic               w_push_fault;

    // Only accept when idle with a free slot: the in-flight word always fits
    assign w_pc_ready = (state_q == IDLE) && !fetch_if.flush && (count_q < CNT_W'(DEPTH));
    assign w_accept   = fetch_if.pc_valid && w_pc_ready;
    assign w_aligned  = (fetch_if.pc_current[1:0] == 2'b00);
    assign w_push_mis = w_accept && !w_aligned;
    assign w_push_mem = (state_q == WAIT) && fetch_if.imem_rvalid && !fetch_if.flush;
    assign w_push     = w_push_mis || w_push_mem;
    assign w_pop      = (count_q != '0) && fetch_if.instr_ready && !fetch_if.flush;

`ifdef IFETCH_BUS_ERR_EN
    logic               fifo_berr_q [DEPTH];
    logic               w_push_berr;
`endif

    always_comb begin
        w_push_instr = NOP_INSTR;
        w_push_pc    = fetch_if.pc_current;
        w_push_fault = 1'b1;
`ifdef IFETCH_BUS_ERR_EN
        w_push_berr  = 1'b0;
`endif
        if (w_push_mem) begin
            w_push_instr = fetch_if.imem_rdata;
            w_push_pc    = imem_addr_q;
            w_push_fault = 1'b0;
`ifdef IFETCH_BUS_ERR_EN
            if (fetch_if.imem_err) begin
                w_push_instr = NOP_INSTR;
                w_push_berr  = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (fetch_if.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) wptr_d = wptr_q + PTR_W'(1);
            if (w_pop)  rptr_d = rptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_fault_q[i] <= 1'b0;
`ifdef IFETCH_BUS_ERR_EN
                fifo_berr_q[i]  <= 1'b0;
`endif
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (w_push) begin
                fifo_instr_q[wptr_q] <= w_push_instr;
                fifo_pc_q[wptr_q]    <= w_push_pc;
                fifo_fault_q[wptr_q] <= w_push_fault;
`ifdef IFETCH_BUS_ERR_EN
                fifo_berr_q[wptr_q]  <= w_push_berr;
`endif
            end
        end
    end

    // flush_seen_q remembers a flush during REQ so the granted response is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept && w_aligned) begin
                        state_q      <= REQ;
                        imem_req_q   <= 1'b1;
                        imem_addr_q  <= fetch_if.pc_current;
                        flush_seen_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (fetch_if.imem_gnt) begin
                        imem_req_q   <= 1'b0;
                        flush_seen_q <= 1'b0;
                        state_q      <= (fetch_if.flush || flush_seen_q) ? DROP : WAIT;
                    end else if (fetch_if.flush) begin
                        flush_seen_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (fetch_if.imem_rvalid) begin
                        state_q <= IDLE;
                    end else if (fetch_if.flush) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (fetch_if.imem_rvalid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fetch_if.pc_ready    = w_pc_ready;
    assign fetch_if.imem_req    = imem_req_q;
    assign fetch_if.imem_addr   = imem_addr_q;
    assign fetch_if.instr_valid = (count_q != '0);
    assign fetch_if.instr       = fifo_instr_q[rptr_q];
    assign fetch_if.instr_pc    = fifo_pc_q[rptr_q];
    assign fetch_if.instr_fault = fifo_fault_q[rptr_q];
`ifdef IFETCH_BUS_ERR_EN
    assign fetch_if.instr_bus_err = fifo_berr_q[rptr_q];
`endif

endmodule

`default_nettype wire
